// File: rtl/mem_stage_sx_if.sv
// Signal bundle around the MEM stage: EX handoff, WB handoff, data-SRAM response and ID forwarding.
// master = surrounding pipeline/SRAM side, slave = the MEM stage itself.
interface mem_stage_sx_if #(
    parameter int ES_TO_MS_BUS_WD = 107,
    parameter int MS_TO_WS_BUS_WD = 70
);
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       es_mem_inflight;
    logic                       ms_flush;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [38:0]                ms_fwd_bus;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, es_mem_inflight, ms_flush,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, es_mem_inflight, ms_flush,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );
endinterface

// File: rtl/mem_stage_sx.sv
// MIPS MEM stage: waits for split-transaction data_ok, extends sub-word loads, buffers under WB stall,
// discards responses of flushed requests. Define MS_UNALIGNED_LWLR_EN to enable lwl/lwr merging.
module mem_stage_sx #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ES_TO_MS_BUS_WD = 107,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic          clk,
    input  logic          resetn,
    mem_stage_sx_if.slave ms_if
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(MAX_OUTSTANDING);

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q, ms_bus_d;
    logic                       resp_got_q, resp_got_d;
    logic [31:0]                resp_buf_q, resp_buf_d;
    logic [CNT_W-1:0]           discard_cnt_q, discard_cnt_d;

    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic        wait_resp;
    logic [31:0] rt_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {res_from_mem, ld_op, wait_resp, rt_value, gr_we, dest, alu_result, pc} = ms_bus_q;

    logic        flush;
    logic        data_ok;
    logic        ws_allowin;
    logic        cnt_zero;
    logic        resp_take;
    logic        resp_drop;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic        ms_leave;
    logic        pend_kill;
    logic [CNT_W:0] cnt_sum;

    assign flush      = ms_if.ms_flush;
    assign data_ok    = ms_if.data_sram_data_ok;
    assign ws_allowin = ms_if.ws_allowin;
    assign cnt_zero   = (discard_cnt_q == '0);
    assign resp_take  = data_ok && cnt_zero;
    assign resp_drop  = data_ok && !cnt_zero;

    assign ms_ready_go = !wait_resp || resp_got_q || resp_take;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_leave    = ms_valid_q && (flush || (ms_ready_go && ws_allowin));

    // The MS entry's own request is still outstanding only if no response has been taken for it.
    assign pend_kill = ms_valid_q && wait_resp && !resp_got_q && !resp_take;
    assign cnt_sum   = {1'b0, discard_cnt_q} - (CNT_W+1)'(resp_drop)
                     + (flush ? ((CNT_W+1)'(pend_kill) + (CNT_W+1)'(ms_if.es_mem_inflight)) : '0);

    // Load data path: buffered word wins once captured, otherwise pass rdata straight through.
    logic [31:0] mem_word;
    logic [7:0]  mem_byte [4];
    logic [1:0]  off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign mem_word = resp_got_q ? resp_buf_q : ms_if.data_sram_rdata;
    assign off      = alu_result[1:0];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign mem_byte[gi] = mem_word[8*gi +: 8];
    end

`ifndef MS_UNALIGNED_LWLR_EN
    logic unused_rt;
    assign unused_rt = ^rt_value;
`endif

    always_comb begin
        sel_byte  = mem_byte[off];
        sel_half  = off[1] ? mem_word[31:16] : mem_word[15:0];
        load_data = mem_word;
        case (ld_op)
            3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b010:  load_data = {24'h0, sel_byte};
            3'b011:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {16'h0, sel_half};
`ifdef MS_UNALIGNED_LWLR_EN
            3'b101: begin
                case (off)
                    2'd0:    load_data = {mem_byte[0], rt_value[23:0]};
                    2'd1:    load_data = {mem_byte[1], mem_byte[0], rt_value[15:0]};
                    2'd2:    load_data = {mem_byte[2], mem_byte[1], mem_byte[0], rt_value[7:0]};
                    default: load_data = mem_word;
                endcase
            end
            3'b110: begin
                case (off)
                    2'd0:    load_data = mem_word;
                    2'd1:    load_data = {rt_value[31:24], mem_byte[3], mem_byte[2], mem_byte[1]};
                    2'd2:    load_data = {rt_value[31:16], mem_byte[3], mem_byte[2]};
                    default: load_data = {rt_value[31:8], mem_byte[3]};
                endcase
            end
`endif
            default: load_data = mem_word;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    always_comb begin
        ms_valid_d    = ms_valid_q;
        ms_bus_d      = ms_bus_q;
        resp_got_d    = resp_got_q;
        resp_buf_d    = resp_buf_q;
        discard_cnt_d = discard_cnt_q;

        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = ms_if.es_to_ms_valid;
        end

        if (ms_if.es_to_ms_valid && ms_allowin && !flush) begin
            ms_bus_d = ms_if.es_to_ms_bus;
        end

        // A response already captured is never overwritten by a later strobe.
        if (ms_leave) begin
            resp_got_d = 1'b0;
            resp_buf_d = '0;
        end else if (ms_valid_q && wait_resp && !resp_got_q && resp_take) begin
            resp_got_d = 1'b1;
            resp_buf_d = ms_if.data_sram_rdata;
        end

        if (cnt_sum > CNT_MAX) begin
            discard_cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            discard_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            ms_bus_q      <= '0;
            resp_got_q    <= 1'b0;
            resp_buf_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            ms_bus_q      <= ms_bus_d;
            resp_got_q    <= resp_got_d;
            resp_buf_q    <= resp_buf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // More cancelled requests than the counter can hold means the core broke its outstanding limit.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (cnt_sum <= CNT_MAX);
        end
    end

    assign ms_if.ms_allowin     = ms_allowin;
    assign ms_if.ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    assign ms_if.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign ms_if.ms_fwd_bus     = (ms_valid_q && gr_we)
                                ? {res_from_mem && !ms_ready_go, 1'b1, dest, final_result}
                                : '0;
endmodule

// File: tb/tb_mem_stage_sx.sv
// Bench for mem_stage_sx: directed cases for the listed corner scenarios, then a randomized pipeline
// with a transaction-level model; WB handoffs are checked from a scoreboard queue by a monitor.
module tb_mem_stage_sx;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_sx_if bus_if ();

    mem_stage_sx #(
        .MAX_OUTSTANDING(2),
        .ES_TO_MS_BUS_WD(107),
        .MS_TO_WS_BUS_WD(70)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .ms_if (bus_if)
    );

    typedef struct {
        bit        res;
        bit        wt;
        bit        we;
        bit        mem;
        bit [2:0]  ld;
        bit [31:0] rt;
        bit [4:0]  dest;
        bit [31:0] alu;
        bit [31:0] pc;
    } instr_t;

    typedef struct {
        int owner;   // -1: request of a flushed instruction
        int cyc;
    } req_t;

    int total = 0;
    int bad   = 0;
    logic [69:0] exp_q [$];

    task automatic check(string name, logic [69:0] act, logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [106:0] pack(instr_t i);
        return {i.res, i.ld, i.wt, i.rt, i.we, i.dest, i.alu, i.pc};
    endfunction

    function automatic instr_t mk(bit res, bit [2:0] ld, bit [31:0] rt, bit [4:0] dest,
                                  bit [31:0] alu, bit [31:0] pc);
        instr_t i;
        i.res = res; i.wt = 1'b1; i.mem = 1'b1; i.we = 1'b1; i.ld = ld;
        i.rt = rt; i.dest = dest; i.alu = alu; i.pc = pc;
        return i;
    endfunction

    // Reference result from the load rules, expressed as shifts and masks on the whole word.
    function automatic logic [31:0] ref_result(instr_t i, logic [31:0] w);
        int off;
        logic [31:0] sh;
        logic [31:0] m;
        if (!i.res) return i.alu;
        off = int'(i.alu[1:0]);
        sh  = w >> (8 * off);
        m   = 32'h0;
        case (i.ld)
            3'd1: return {{24{sh[7]}}, sh[7:0]};
            3'd2: return {24'h0, sh[7:0]};
            3'd3: begin sh = w >> (16 * (off / 2)); return {{16{sh[15]}}, sh[15:0]}; end
            3'd4: begin sh = w >> (16 * (off / 2)); return {16'h0, sh[15:0]}; end
`ifdef MS_UNALIGNED_LWLR_EN
            3'd5: begin
                m = (32'h1 << (8 * (3 - off))) - 32'h1;
                return (w << (8 * (3 - off))) | (i.rt & m);
            end
            3'd6: begin
                m = 32'hFFFF_FFFF >> (8 * off);
                return (w >> (8 * off)) | (i.rt & ~m);
            end
`endif
            default: return w + m;
        endcase
    endfunction

    function automatic instr_t rand_instr(int id);
        instr_t i;
        int kind;
        kind   = int'($urandom_range(3));
        i.rt   = $urandom;
        i.alu  = $urandom;
        i.dest = 5'($urandom);
        i.ld   = 3'($urandom);
        i.pc   = 32'h1000 + 32'(id * 4);
        i.mem  = (kind >= 2);
        i.wt   = i.mem;
        i.res  = (kind == 2);
        i.we   = (kind == 3) ? 1'b0 : ($urandom_range(7) != 0);
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_mem_inflight   = 1'b0;
        bus_if.ms_flush          = 1'b0;
        bus_if.data_sram_data_ok = 1'b0;
    endtask

    task automatic issue(instr_t i);
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = pack(i);
        tick();
        bus_if.es_to_ms_valid = 1'b0;
    endtask

    // Scoreboard monitor: every WB handoff consumes one expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus_if.ms_to_ws_valid === 1'b1 && bus_if.ws_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got %h want nothing", bus_if.ms_to_ws_bus);
            end else begin
                $display("wb handoff: bus=%h", bus_if.ms_to_ws_bus);
                check("wb_bus", bus_if.ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    instr_t ex, ms, li;
    bit ex_v, ms_v, ms_got;
    logic [31:0] ms_data;
    int ex_id, ms_id, next_id, killed_out, kills;
    req_t req_q [$];
    bit ws, dok, fl, resp_ms, ready, allow, evalid;
    logic [31:0] rd, sel, fres;
    logic [38:0] efwd;

    initial begin
        resetn = 1'b0;
        quiet();
        bus_if.ws_allowin      = 1'b1;
        bus_if.es_to_ms_bus    = '0;
        bus_if.data_sram_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid",   70'(bus_if.ms_to_ws_valid), 70'(0));
        check("rst_allowin", 70'(bus_if.ms_allowin), 70'(1));
        check("rst_fwd",     70'(bus_if.ms_fwd_bus), 70'(0));
        tick();
        resetn = 1'b1;

        // lb at offset 2, response three cycles after entry
        li = mk(1'b1, 3'd1, 32'h0, 5'd5, 32'h0000_1002, 32'h100);
        issue(li);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lb_blk",   70'(bus_if.ms_fwd_bus[38]), 70'(1));
            check("lb_noout", 70'(bus_if.ms_to_ws_valid), 70'(0));
            tick();
        end
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h1280_3456;
        exp_q.push_back({1'b1, 5'd5, 32'hFFFF_FF80, 32'h100});
        @(negedge clk);
        check("lb_fwd", 70'(bus_if.ms_fwd_bus), 70'({1'b0, 1'b1, 5'd5, 32'hFFFF_FF80}));
        tick();
        bus_if.data_sram_data_ok = 1'b0;

        // lbu of the same word
        li = mk(1'b1, 3'd2, 32'h0, 5'd6, 32'h0000_1002, 32'h104);
        issue(li);
        bus_if.data_sram_data_ok = 1'b1;
        exp_q.push_back({1'b1, 5'd6, 32'h0000_0080, 32'h104});
        tick();
        bus_if.data_sram_data_ok = 1'b0;

        // response during WB stall is buffered; rdata changes afterwards
        li = mk(1'b1, 3'd0, 32'h0, 5'd7, 32'h0000_2000, 32'h200);
        issue(li);
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hCAFE_F00D;
        exp_q.push_back({1'b1, 5'd7, 32'hCAFE_F00D, 32'h200});
        @(negedge clk);
        check("stall_valid0", 70'(bus_if.ms_to_ws_valid), 70'(1));
        tick();
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stall_valid1", 70'(bus_if.ms_to_ws_valid), 70'(1));
        check("stall_allow",  70'(bus_if.ms_allowin), 70'(0));
        check("stall_fwd",    70'(bus_if.ms_fwd_bus), 70'({1'b0, 1'b1, 5'd7, 32'hCAFE_F00D}));
        tick();
        bus_if.ws_allowin = 1'b1;
        tick();
        @(negedge clk);
        check("stall_once", 70'(bus_if.ms_to_ws_valid), 70'(0));
        check("stall_free", 70'(bus_if.ms_allowin), 70'(1));
        tick();

        // flush with pending MS load and EX request in flight: two responses dropped
        li = mk(1'b1, 3'd0, 32'h0, 5'd8, 32'h0000_3000, 32'h300);
        issue(li);
        bus_if.es_to_ms_valid  = 1'b1;
        bus_if.es_to_ms_bus    = pack(mk(1'b1, 3'd0, 32'h0, 5'd9, 32'h0, 32'h304));
        bus_if.es_mem_inflight = 1'b1;
        bus_if.ms_flush        = 1'b1;
        @(negedge clk);
        check("fl_noout", 70'(bus_if.ms_to_ws_valid), 70'(0));
        tick();
        quiet();
        li = mk(1'b1, 3'd0, 32'h0, 5'd10, 32'h0000_3008, 32'h308);
        issue(li);
        for (int k = 0; k < 2; k++) begin
            bus_if.data_sram_data_ok = 1'b1;
            bus_if.data_sram_rdata   = $urandom;
            @(negedge clk);
            check("fl_drop", 70'(bus_if.ms_to_ws_valid), 70'(0));
            tick();
        end
        bus_if.data_sram_rdata = 32'h1357_9BDF;
        exp_q.push_back({1'b1, 5'd10, 32'h1357_9BDF, 32'h308});
        @(negedge clk);
        check("fl_third", 70'(bus_if.ms_to_ws_valid), 70'(1));
        tick();
        bus_if.data_sram_data_ok = 1'b0;

        // flush in the same cycle as the MS load's data_ok: counter stays zero
        li = mk(1'b1, 3'd0, 32'h0, 5'd11, 32'h0000_4000, 32'h400);
        issue(li);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h0000_0055;
        bus_if.ms_flush          = 1'b1;
        @(negedge clk);
        check("flok_noout", 70'(bus_if.ms_to_ws_valid), 70'(0));
        tick();
        quiet();
        li = mk(1'b1, 3'd0, 32'h0, 5'd12, 32'h0000_4004, 32'h404);
        issue(li);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h2468_ACE0;
        exp_q.push_back({1'b1, 5'd12, 32'h2468_ACE0, 32'h404});
        @(negedge clk);
        check("flok_next", 70'(bus_if.ms_to_ws_valid), 70'(1));
        tick();
        bus_if.data_sram_data_ok = 1'b0;

        // lwl at offset 1
        li = mk(1'b1, 3'd5, 32'hAABB_CCDD, 5'd13, 32'h0000_5001, 32'h500);
        issue(li);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h1122_3344;
`ifdef MS_UNALIGNED_LWLR_EN
        exp_q.push_back({1'b1, 5'd13, 32'h3344_CCDD, 32'h500});
`else
        exp_q.push_back({1'b1, 5'd13, 32'h1122_3344, 32'h500});
`endif
        tick();
        bus_if.data_sram_data_ok = 1'b0;

        // reset abandons a pending load; a stale data_ok is ignored
        li = mk(1'b1, 3'd0, 32'h0, 5'd14, 32'h0000_6000, 32'h600);
        issue(li);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h0000_0077;
        @(negedge clk);
        check("rst_stale_valid", 70'(bus_if.ms_to_ws_valid), 70'(0));
        check("rst_stale_allow", 70'(bus_if.ms_allowin), 70'(1));
        check("rst_stale_fwd",   70'(bus_if.ms_fwd_bus), 70'(0));
        tick();
        quiet();

        // randomized pipeline against the transaction-level model
        ex_v = 1'b0; ms_v = 1'b0; ms_got = 1'b0; ms_data = '0;
        ex_id = 0; ms_id = -2; next_id = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ws = ($urandom_range(3) != 0);
            if (!ex_v && $urandom_range(2) != 0) begin
                ex    = rand_instr(next_id);
                ex_id = next_id;
                next_id++;
                ex_v  = 1'b1;
                if (ex.mem) req_q.push_back('{ex_id, cyc});
            end

            rd = $urandom;
            dok = 1'b0;
            resp_ms = 1'b0;
            if (req_q.size() > 0) begin
                if (req_q[0].cyc < cyc && (req_q[0].owner < 0 || (ms_v && req_q[0].owner == ms_id))
                    && $urandom_range(1) == 1) begin
                    dok     = 1'b1;
                    resp_ms = (req_q[0].owner >= 0);
                    void'(req_q.pop_front());
                end
            end else if ($urandom_range(7) == 0) begin
                dok = 1'b1;
            end

            killed_out = 0;
            foreach (req_q[k]) if (req_q[k].owner < 0) killed_out++;
            kills = int'(ms_v && ms.wt && !ms_got && !resp_ms) + int'(ex_v && ex.mem);
            fl = ($urandom_range(15) == 0) && (killed_out + kills <= 2);

            ready  = !ms.wt || ms_got || resp_ms;
            sel    = ms_got ? ms_data : rd;
            fres   = ref_result(ms, sel);
            efwd   = (ms_v && ms.we) ? {ms.res && !ready, 1'b1, ms.dest, fres} : 39'h0;
            allow  = !ms_v || (ready && ws);
            evalid = ms_v && ready && !fl;

            bus_if.ws_allowin        = ws;
            bus_if.es_to_ms_valid    = ex_v;
            bus_if.es_to_ms_bus      = pack(ex);
            bus_if.es_mem_inflight   = ex_v && ex.mem;
            bus_if.ms_flush          = fl;
            bus_if.data_sram_data_ok = dok;
            bus_if.data_sram_rdata   = rd;
            if (evalid && ws) exp_q.push_back({ms.we, ms.dest, fres, ms.pc});

            if (fl) begin
                foreach (req_q[k]) begin
                    if ((ms_v && req_q[k].owner == ms_id) || (ex_v && req_q[k].owner == ex_id))
                        req_q[k].owner = -1;
                end
                ms_v = 1'b0; ms_got = 1'b0; ex_v = 1'b0;
            end else begin
                if (resp_ms) begin
                    ms_got  = 1'b1;
                    ms_data = rd;
                end
                if (allow) begin
                    ms_v   = ex_v;
                    ms     = ex;
                    ms_id  = ex_v ? ex_id : -2;
                    ms_got = 1'b0;
                    ex_v   = 1'b0;
                end
            end

            @(negedge clk);
            check("rnd_fwd",     70'(bus_if.ms_fwd_bus), 70'(efwd));
            check("rnd_allowin", 70'(bus_if.ms_allowin), 70'(allow));
            check("rnd_valid",   70'(bus_if.ms_to_ws_valid), 70'(evalid));
            tick();
        end
        quiet();
        tick();
        check("sb_empty", 70'(exp_q.size()), 70'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_sx.md
# mem_stage_sx

Memory-access pipeline stage for the 5-stage MIPS core with a split-transaction data-SRAM interface. The stage sits between EX and WB. It holds one instruction and waits for the SRAM `data_ok` response on loads and stores. It sign- or zero-extends sub-word load data, buffers the response while WB stalls, and drops responses that belong to flushed instructions. It also drives a forwarding/blocking bus back to ID.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum in-flight data requests that can be cancelled; sizes the discard counter (`$clog2(MAX_OUTSTANDING+1)` bits).
- `ES_TO_MS_BUS_WD`, default 107: EX→MS bus width.
- `MS_TO_WS_BUS_WD`, default 70: MS→WB bus width.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `ws_allowin` in 1: WB can accept.
- `ms_allowin` out 1: MS can accept.
- `es_to_ms_valid` in 1: EX output valid.
- `es_to_ms_bus` in 107: `{res_from_mem[106], ld_op[105:103], wait_resp[102], rt_value[101:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}`.
- `es_mem_inflight` in 1: EX has a data request accepted (`addr_ok` seen) that is not yet in MS.
- `ms_flush` in 1: exception/eret flush; kills MS contents this cycle.
- `ms_to_ws_valid` out 1: MS output valid.
- `ms_to_ws_bus` out 70: `{gr_we, dest[4:0], final_result[31:0], pc[31:0]}`.
- `data_sram_data_ok` in 1: response strobe.
- `data_sram_rdata` in 32: response data; valid only with `data_ok`.
- `ms_fwd_bus` out 39: `{blk, we, dest[4:0], result[31:0]}` to ID.

## Operation
- Capture: bus register loads when `es_to_ms_valid && ms_allowin && !ms_flush`. `ms_valid <= es_to_ms_valid && !ms_flush` when `ms_allowin`. `ms_flush` alone clears `ms_valid`.
- Response tracking:
  - `resp_got` flag and `resp_buf[31:0]`.
  - An accepted `data_ok` (see discard) for a valid MS entry with `wait_resp` sets `resp_got` and stores `rdata`.
  - Both clear when the entry leaves MS.
- `ms_ready_go = !wait_resp || resp_got || (data_ok && discard_cnt==0)`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush`.
- Read data mux: `resp_got ? resp_buf : data_sram_rdata`. Byte offset is `off = alu_result[1:0]`.
- `ld_op` decode:
  - 000 lw: word.
  - 001 lb / 010 lbu: byte `off`, sign/zero-extended.
  - 011 lh / 100 lhu: half `off[1]`, sign/zero-extended.
  - 101 lwl, 110 lwr: see Configuration.
  - 111: treated as lw.
- `final_result = res_from_mem ? load_data : alu_result`.
- Discard counter:
  - On `ms_flush`, `discard_cnt += (ms_valid && wait_resp && !resp_got && !data_ok) + es_mem_inflight`.
  - Each `data_ok` while `discard_cnt>0` decrements it, and that response is dropped.
  - Flush and a `data_ok` in the same cycle: the decrement applies first, then the increment (net result computed in one update).
  - The counter saturates at `MAX_OUTSTANDING`; exceeding it is a design error and is flagged by a simulation assertion.
- Forward bus:
  - All zero when `!ms_valid || !gr_we`.
  - Otherwise `blk = res_from_mem && !ms_ready_go`, `we=1`, `dest`, `result = final_result`.

## Timing
- Reset (`resetn==0` at a clock edge):
  - `ms_valid=0`, `resp_got=0`, `discard_cnt=0`, `resp_buf=0`.
  - Outputs: `ms_to_ws_valid=0`, `ms_allowin=1`, `ms_fwd_bus=0`.
  - A reset in the middle of a transaction abandons it; a `data_ok` arriving after reset is ignored because `ms_valid=0`.
- Non-memory op: zero added latency; enters at edge N, visible to WB at edge N+1 if `ws_allowin`.
- Load or store:
  - Completes in the cycle `data_ok` is seen (combinational pass-through of `rdata`).
  - If `ws_allowin=0` in that cycle, data is buffered and forwarded once WB frees; `rdata` is not re-sampled.
- `data_ok` with `ms_valid=0` and `discard_cnt==0` is ignored.
- `ms_flush` overrides `ws_allowin`: no handoff happens in a flush cycle.

## Configuration
- `MS_UNALIGNED_LWLR_EN` defined:
  - lwl, rt merged by `off`:
    - 0: `{b0, rt[23:0]}`
    - 1: `{b1,b0, rt[15:0]}`
    - 2: `{b2,b1,b0, rt[7:0]}`
    - 3: word.
  - lwr, rt merged by `off`:
    - 0: word
    - 1: `{rt[31:24], b3,b2,b1}`
    - 2: `{rt[31:16], b3,b2}`
    - 3: `{rt[31:8], b3}`.
- Undefined: `ld_op` 101/110 behave as lw, and `rt_value` is unused.

## Test plan
- lb, `alu_result=0x...2`, `rdata=0x12_80_34_56`, `data_ok` 3 cycles after entry → `blk=1` for 3 cycles, then `final_result=0xFFFFFF80`. lbu of the same → `0x00000080`.
- Load with `data_ok` arriving while `ws_allowin=0` for 2 cycles, `rdata` changing afterwards → WB receives the captured word once; `ms_valid` is held throughout.
- Flush with a pending MS load and `es_mem_inflight=1` → `discard_cnt=2`; the next two `data_ok` are dropped; the third completes the new load.
- Flush in the same cycle as `data_ok` for the MS load → response consumed, `discard_cnt` stays 0, no WB handoff.
- lwl `off=1`, `rt=0xAABBCCDD`, `rdata=0x11223344` → `0x3344CCDD` with the macro, `0x11223344` without.
- `resetn` low while a load is pending, then a stale `data_ok` arrives → no output, `ms_allowin=1`, `ms_fwd_bus=0`.
